multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM that sequences the shared single-port CPU datapath (regfile, result ALU, PC ALU, DwMux, DbMux, addrMux, dataMemory) as a multicycle machine.
- Drives every decoder-owned select and enable, one step per clock: fetch, decode, execute, memory, writeback.
- Instruction fetch and data access share `dataMemory` through `addrMux`, so they occupy different cycles.
- Inputs are instruction-register fields and the ALU zero flag. Outputs are registered state decoded to control lines.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26], stable from DECODE until the next FETCH.
- funct  in  6  IR[5:0].
- zeroFlag  in  1  result-ALU zero flag, sampled in EXEC.
- resAluOp  out  3  result-ALU command.
- DwSel  out  2  regfile write-data select: 0 resAluRes, 1 pcAluRes, 2 memOut.
- AwSel  out  2  write-address select: 0 rt, 1 rd, 2 constant 31.
- immSel  out  1  1 = sign-extended immediate into ALU B.
- memAddrSel  out  1  1 = PC drives memory address (fetch).
- regWrEn  out  1  regfile write enable.
- memWrEn  out  1  data memory write enable.
- irWrEn  out  1  load instruction register from memOut.
- pcWrEn  out  1  update PC.
- pcSrc  out  2  PC source: 0 pc+4, 1 branch target, 2 jump target, 3 Da (jr).
- err  out  1  sticky illegal-instruction flag.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, ERROR. State is registered; outputs are combinational from state, opcode and funct. Any output not listed for a state is 0.
- Reset: when `reset` is high at a clock edge, state goes to FETCH, `err` to 0 and `retired` to 0. While `reset` is high, `regWrEn`, `memWrEn`, `irWrEn` and `pcWrEn` are forced to 0.
- Reset mid-instruction aborts the instruction with no further writes.
- FETCH: memAddrSel=1, irWrEn=1, pcWrEn=1, pcSrc=0. Next state DECODE.
- DECODE, by opcode:
  - J: pcWrEn=1, pcSrc=2, then FETCH.
  - JAL: go to WB.
  - R-type with funct JR: go to EXEC.
  - LW, SW, ADDI, XORI, BEQ, BNE, R-type ADD/SUB/SLT: go to EXEC.
  - Anything else: go to ERROR.
- EXEC:
  - LW/SW: immSel=1, resAluOp=ADD, next MEM.
  - ADDI: immSel=1, resAluOp=ADD, next WB.
  - XORI: immSel=1, resAluOp=XOR, next WB.
  - R-type: resAluOp from funct, next WB.
  - BEQ: resAluOp=SUB; pcWrEn=zeroFlag, pcSrc=1; next FETCH.
  - BNE: resAluOp=SUB; pcWrEn=!zeroFlag, pcSrc=1; next FETCH.
  - JR: pcWrEn=1, pcSrc=3, next FETCH.
- MEM: immSel=1, resAluOp=ADD, memAddrSel=0 (the address is held by the datapath).
  - SW: memWrEn=1, next FETCH.
  - LW: next WB.
- WB: regWrEn=1, then FETCH.
  - LW: DwSel=2, AwSel=0.
  - ADDI/XORI: DwSel=0, AwSel=0, ALU inputs held as in EXEC.
  - R-type: DwSel=0, AwSel=1.
  - JAL: DwSel=1, AwSel=2, pcWrEn=1, pcSrc=2. The link value is pc+4 from the PC ALU, because PC was already advanced in FETCH.
- ERROR: all enables 0, err=1, state held until reset.
- Cycles per instruction: J 2; BEQ, BNE, JR, JAL 3; R-type, ADDI, XORI, SW 4; LW 5.
- `retired` increments by 1 on the final cycle of each legal instruction (the edge that returns the FSM to FETCH). It wraps modulo 2^RETIRE_W.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - Opcodes: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, XORI 0x0E, ADDI 0x08, RTYPE 0x00.
  - Functs: ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
  - ALU commands: ADD 0, SUB 1, XOR 2, SLT 3, AND 4, NAND 5, NOR 6, OR 7.
  - State enum, plus DwSel, AwSel and pcSrc encodings.
- Sub-module `alu_op_decode`: combinational mapping of opcode/funct to resAluOp, shared by EXEC and WB.

Test Plan:
- ADD r3,r1,r2 after reset: FETCH irWrEn=1/pcWrEn=1, then DECODE, then EXEC resAluOp=0, then WB regWrEn=1, DwSel=0, AwSel=1. retired 0→1 after 4 cycles.
- LW then SW: LW shows MEM with memAddrSel=0, then WB with DwSel=2. SW shows memWrEn=1 for exactly one cycle, regWrEn never asserted. Cycle counts are 5 and 4.
- BEQ with zeroFlag=1: pcWrEn=1, pcSrc=1 in EXEC. Repeat with zeroFlag=0: pcWrEn=0. BNE gives the inverse. Each takes 3 cycles.
- JAL: WB asserts regWrEn with AwSel=2, DwSel=1, and pcWrEn with pcSrc=2. J completes in 2 cycles with no regWrEn.
- Opcode 0x3F in DECODE: ERROR reached, err=1, all enables stay 0 for 10 cycles, retired frozen. Reset returns to FETCH with err=0.
- reset pulsed during LW MEM: no WB regWrEn follows, next state FETCH, retired=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, functs,
// ALU commands, FSM states, mux selects and the bundled control word.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DW_ALU = 2'd0,
    DW_PC  = 2'd1,
    DW_MEM = 2'd2
  } dw_sel_e;

  typedef enum logic [1:0] {
    AW_RT = 2'd0,
    AW_RD = 2'd1,
    AW_RA = 2'd2
  } aw_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_src_e;

  typedef struct packed {
    alu_op_e res_alu_op;
    dw_sel_e dw_sel;
    aw_sel_e aw_sel;
    logic    imm_sel;
    logic    mem_addr_sel;
    logic    reg_wr_en;
    logic    mem_wr_en;
    logic    ir_wr_en;
    logic    pc_wr_en;
    pc_src_e pc_src;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    case (opcode)
      OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_XORI, OP_ADDI: return 1'b1;
      OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) ||
                       (funct == FN_SLT) || (funct == FN_JR);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, control lines out.
interface multicycle_ctrl_if #(
  parameter int RETIRE_W = 32
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  zeroFlag;
  cpu_ctrl_pkg::alu_op_e resAluOp;
  cpu_ctrl_pkg::dw_sel_e DwSel;
  cpu_ctrl_pkg::aw_sel_e AwSel;
  logic                  immSel;
  logic                  memAddrSel;
  logic                  regWrEn;
  logic                  memWrEn;
  logic                  irWrEn;
  logic                  pcWrEn;
  cpu_ctrl_pkg::pc_src_e pcSrc;
  logic                  err;
  logic [RETIRE_W-1:0]   retired;

  modport master (
    input  opcode, funct, zeroFlag,
    output resAluOp, DwSel, AwSel, immSel, memAddrSel, regWrEn, memWrEn,
           irWrEn, pcWrEn, pcSrc, err, retired
  );

  modport slave (
    output opcode, funct, zeroFlag,
    input  resAluOp, DwSel, AwSel, immSel, memAddrSel, regWrEn, memWrEn,
           irWrEn, pcWrEn, pcSrc, err, retired
  );

endinterface

// File: rtl/alu_op_decode.sv
// Maps opcode/funct to the result-ALU command; shared by the EXEC and WB steps.
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_XORI:        alu_op = ALU_XOR;
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_RTYPE: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      default:        alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the shared single-port datapath:
// FETCH -> DECODE -> EXEC -> MEM -> WB, with a sticky ERROR trap.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  alu_op_e             dec_alu_op;
  ctrl_t               ctrl;

  wire is_rtype = (bus.opcode == OP_RTYPE);
  wire is_jr    = is_rtype && (bus.funct == FN_JR);

  alu_op_decode u_alu_op_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .alu_op (dec_alu_op)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (!is_legal(bus.opcode, bus.funct)) state_d = ST_ERROR;
        else if (bus.opcode == OP_J)          state_d = ST_FETCH;
        else if (bus.opcode == OP_JAL)        state_d = ST_WB;
        else                                  state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = ST_MEM;
          OP_BEQ, OP_BNE: state_d = ST_FETCH;
          default:        state_d = is_jr ? ST_FETCH : ST_WB;
        endcase
      end
      ST_MEM:   state_d = (bus.opcode == OP_SW) ? ST_FETCH : ST_WB;
      ST_WB:    state_d = ST_FETCH;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_FETCH;
    endcase

    // The only way back into FETCH is completing a legal instruction.
    retire    = (state_q != ST_FETCH) && (state_d == ST_FETCH);
    retired_d = retired_q + RETIRE_W'(retire);
    err_d     = err_q | (state_d == ST_ERROR);
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_addr_sel = 1'b1;
        ctrl.ir_wr_en     = 1'b1;
        ctrl.pc_wr_en     = 1'b1;
        ctrl.pc_src       = PC_PLUS4;
      end
      ST_DECODE: begin
        if (bus.opcode == OP_J) begin
          ctrl.pc_wr_en = 1'b1;
          ctrl.pc_src   = PC_JUMP;
        end
      end
      ST_EXEC: begin
        ctrl.res_alu_op = dec_alu_op;
        case (bus.opcode)
          OP_LW, OP_SW, OP_ADDI, OP_XORI: ctrl.imm_sel = 1'b1;
          OP_BEQ: begin
            ctrl.pc_wr_en = bus.zeroFlag;
            ctrl.pc_src   = PC_BRANCH;
          end
          OP_BNE: begin
            ctrl.pc_wr_en = !bus.zeroFlag;
            ctrl.pc_src   = PC_BRANCH;
          end
          default: begin
            if (is_jr) begin
              ctrl.pc_wr_en = 1'b1;
              ctrl.pc_src   = PC_REG;
            end
          end
        endcase
      end
      ST_MEM: begin
        ctrl.imm_sel    = 1'b1;
        ctrl.res_alu_op = ALU_ADD;
        ctrl.mem_wr_en  = (bus.opcode == OP_SW);
      end
      ST_WB: begin
        ctrl.reg_wr_en  = 1'b1;
        ctrl.res_alu_op = dec_alu_op;
        case (bus.opcode)
          OP_LW: begin
            ctrl.dw_sel = DW_MEM;
            ctrl.aw_sel = AW_RT;
          end
          OP_ADDI, OP_XORI: begin
            ctrl.dw_sel  = DW_ALU;
            ctrl.aw_sel  = AW_RT;
            ctrl.imm_sel = 1'b1;
          end
          OP_JAL: begin
            // Link is pc+4 from the PC ALU since FETCH already advanced the PC.
            ctrl.dw_sel   = DW_PC;
            ctrl.aw_sel   = AW_RA;
            ctrl.pc_wr_en = 1'b1;
            ctrl.pc_src   = PC_JUMP;
          end
          default: begin
            ctrl.dw_sel = DW_ALU;
            ctrl.aw_sel = AW_RD;
          end
        endcase
      end
      default: ctrl = '0;
    endcase

    if (reset) begin
      ctrl.reg_wr_en = 1'b0;
      ctrl.mem_wr_en = 1'b0;
      ctrl.ir_wr_en  = 1'b0;
      ctrl.pc_wr_en  = 1'b0;
    end
  end

  assign bus.resAluOp   = ctrl.res_alu_op;
  assign bus.DwSel      = ctrl.dw_sel;
  assign bus.AwSel      = ctrl.aw_sel;
  assign bus.immSel     = ctrl.imm_sel;
  assign bus.memAddrSel = ctrl.mem_addr_sel;
  assign bus.regWrEn    = ctrl.reg_wr_en;
  assign bus.memWrEn    = ctrl.mem_wr_en;
  assign bus.irWrEn     = ctrl.ir_wr_en;
  assign bus.pcWrEn     = ctrl.pc_wr_en;
  assign bus.pcSrc      = ctrl.pc_src;
  assign bus.err        = err_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full control word against hand-derived values.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  multicycle_ctrl_if #(.RETIRE_W(32)) bus ();

  multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {resAluOp, DwSel, AwSel, immSel, memAddrSel, regWrEn, memWrEn, irWrEn, pcWrEn, pcSrc, err}
  logic [15:0] ctl_obs;
  assign ctl_obs = {bus.resAluOp, bus.DwSel, bus.AwSel, bus.immSel, bus.memAddrSel,
                    bus.regWrEn, bus.memWrEn, bus.irWrEn, bus.pcWrEn, bus.pcSrc, bus.err};

  function automatic logic [15:0] cv(input int alu, input int dw, input int aw,
                                     input int imm, input int ma, input int rw,
                                     input int mw, input int iw, input int pw,
                                     input int ps, input int er);
    return {alu[2:0], dw[1:0], aw[1:0], imm[0], ma[0], rw[0], mw[0], iw[0], pw[0],
            ps[1:0], er[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: settle, compare the control word, move to the next falling edge.
  task automatic step(input string tag, input logic [15:0] exp);
    #1;
    check(tag, {16'h0, ctl_obs}, {16'h0, exp});
    @(negedge clk);
  endtask

  task automatic fetch_step(input string tag, input int exp_retired);
    #1;
    check({tag, "_retired"}, bus.retired, exp_retired);
    check({tag, "_fetch"}, {16'h0, ctl_obs}, {16'h0, cv(0,0,0,0,1,0,0,1,1,0,0)});
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode   = op;
    bus.funct    = fn;
    bus.zeroFlag = z;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set_ir(6'h00, 6'h20, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // In reset: FETCH decode with all write enables masked.
    #1;
    check("reset_ctl", {16'h0, ctl_obs}, {16'h0, cv(0,0,0,0,1,0,0,0,0,0,0)});
    check("reset_retired", bus.retired, 0);
    reset = 1'b0;

    // ADD r3,r1,r2
    set_ir(6'h00, 6'h20, 1'b0);
    fetch_step("add", 0);
    step("add_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("add_exec",   cv(0,0,0,0,0,0,0,0,0,0,0));
    step("add_wb",     cv(0,0,1,0,0,1,0,0,0,0,0));

    // SUB: ALU command follows funct in EXEC and WB
    set_ir(6'h00, 6'h22, 1'b0);
    fetch_step("sub", 1);
    step("sub_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("sub_exec",   cv(1,0,0,0,0,0,0,0,0,0,0));
    step("sub_wb",     cv(1,0,1,0,0,1,0,0,0,0,0));

    // LW: 5 cycles, MEM with address from the datapath, WB from memory
    set_ir(6'h23, 6'h00, 1'b0);
    fetch_step("lw", 2);
    step("lw_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("lw_exec",   cv(0,0,0,1,0,0,0,0,0,0,0));
    step("lw_mem",    cv(0,0,0,1,0,0,0,0,0,0,0));
    step("lw_wb",     cv(0,2,0,0,0,1,0,0,0,0,0));

    // SW: 4 cycles, single memWrEn cycle, no regWrEn
    set_ir(6'h2B, 6'h00, 1'b0);
    fetch_step("sw", 3);
    step("sw_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("sw_exec",   cv(0,0,0,1,0,0,0,0,0,0,0));
    step("sw_mem",    cv(0,0,0,1,0,0,1,0,0,0,0));

    // BEQ taken / not taken, BNE inverse
    set_ir(6'h04, 6'h00, 1'b1);
    fetch_step("beq_z1", 4);
    step("beq_z1_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("beq_z1_exec",   cv(1,0,0,0,0,0,0,0,1,1,0));
    set_ir(6'h04, 6'h00, 1'b0);
    fetch_step("beq_z0", 5);
    step("beq_z0_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("beq_z0_exec",   cv(1,0,0,0,0,0,0,0,0,1,0));
    set_ir(6'h05, 6'h00, 1'b1);
    fetch_step("bne_z1", 6);
    step("bne_z1_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("bne_z1_exec",   cv(1,0,0,0,0,0,0,0,0,1,0));
    set_ir(6'h05, 6'h00, 1'b0);
    fetch_step("bne_z0", 7);
    step("bne_z0_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("bne_z0_exec",   cv(1,0,0,0,0,0,0,0,1,1,0));

    // JR: 3 cycles, PC from Da
    set_ir(6'h00, 6'h08, 1'b0);
    fetch_step("jr", 8);
    step("jr_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("jr_exec",   cv(0,0,0,0,0,0,0,0,1,3,0));

    // XORI and ADDI: immediate operand held into WB
    set_ir(6'h0E, 6'h00, 1'b0);
    fetch_step("xori", 9);
    step("xori_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("xori_exec",   cv(2,0,0,1,0,0,0,0,0,0,0));
    step("xori_wb",     cv(2,0,0,1,0,1,0,0,0,0,0));
    set_ir(6'h08, 6'h00, 1'b0);
    fetch_step("addi", 10);
    step("addi_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("addi_exec",   cv(0,0,0,1,0,0,0,0,0,0,0));
    step("addi_wb",     cv(0,0,0,1,0,1,0,0,0,0,0));

    // JAL: link into r31 and jump in WB
    set_ir(6'h03, 6'h00, 1'b0);
    fetch_step("jal", 11);
    step("jal_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("jal_wb",     cv(0,1,2,0,0,1,0,0,1,2,0));

    // J: 2 cycles, jump in DECODE
    set_ir(6'h02, 6'h00, 1'b0);
    fetch_step("j", 12);
    step("j_decode", cv(0,0,0,0,0,0,0,0,1,2,0));

    // Illegal opcode: trap, enables low, retired frozen
    set_ir(6'h3F, 6'h00, 1'b0);
    fetch_step("illegal", 13);
    step("illegal_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 10; i++) begin
      #1;
      check("error_retired", bus.retired, 13);
      step("error_ctl", cv(0,0,0,0,0,0,0,0,0,0,1));
    end

    // Reset leaves ERROR
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("err_reset_ctl", {16'h0, ctl_obs}, {16'h0, cv(0,0,0,0,1,0,0,0,0,0,0)});
    check("err_reset_retired", bus.retired, 0);
    reset = 1'b0;

    // Reset during LW MEM aborts the write-back
    set_ir(6'h23, 6'h00, 1'b0);
    fetch_step("lw_abort", 0);
    step("lw_abort_decode", cv(0,0,0,0,0,0,0,0,0,0,0));
    step("lw_abort_exec",   cv(0,0,0,1,0,0,0,0,0,0,0));
    #1;
    check("lw_abort_mem", {16'h0, ctl_obs}, {16'h0, cv(0,0,0,1,0,0,0,0,0,0,0)});
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("lw_abort_after", {16'h0, ctl_obs}, {16'h0, cv(0,0,0,0,1,0,0,0,0,0,0)});
    check("lw_abort_retired", bus.retired, 0);
    reset = 1'b0;
    fetch_step("post_abort", 0);
    step("post_abort_decode", cv(0,0,0,0,0,0,0,0,0,0,0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
